// File: rtl/cam_capture_multi.sv
`default_nettype none
// ============================================================================
// cam_capture_multi: oversampled camera capture, RGB555/RGB565/Y/raw assembly
// Revision: 1.0
// ============================================================================
module cam_capture_multi #(
  parameter int ROW_W  = 9,
  parameter int COL_W  = 10,
  parameter int BCNT_W = 11,
  parameter int DEC_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DEC_W-1:0]  decim,
  output logic [15:0]       pixel,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              valid,
  output logic              sof,
  output logic              line_end,
  output logic              frame_done,
  output logic              line_err,
  output logic [7:0]        frame_cnt
);

  // Row counter carries enough extra bits for the largest decimation shift.
  localparam int RW = ROW_W + (1 << DEC_W) - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t state, state_nx;

  // [0]/[1] are the synchronizer stages, [2] is the history bit.
  logic [2:0] pclk_sr;
  logic [2:0] href_sr;
  logic [2:0] vsync_sr;
  logic [7:0] data_d1;
  logic [7:0] data_d2;

  logic pclk_rise;
  logic pclk_fall;
  logic href_rise;
  logic href_fall;
  logic href_on;
  logic vs_rise;
  logic vs_fall;

  logic              start_frame;
  logic              end_frame;
  logic              capturing;

  logic [1:0]        mode_q;
  logic [DEC_W-1:0]  decim_q;
  logic [BCNT_W-1:0] byte_cntr;
  logic [BCNT_W-1:0] line_len;
  logic              len_known;
  logic [RW-1:0]     row_cntr;
  logic [7:0]        even_byte;
  logic              first_pend;

  logic              raw;
  logic [BCNT_W-1:0] pix_idx;
  logic [BCNT_W-1:0] pmask;
  logic [RW-1:0]     rmask;
  logic              keep;
  logic              emit;
  logic              len_bad;
  logic [15:0]       pix_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_d1  <= '0;
      data_d2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], pclk};
      href_sr  <= {href_sr[1:0], href};
      vsync_sr <= {vsync_sr[1:0], vsync};
      data_d1  <= data;
      data_d2  <= data_d1;
    end
  end

  always_comb begin
    pclk_rise = pclk_sr[1] & ~pclk_sr[2];
    pclk_fall = ~pclk_sr[1] & pclk_sr[2];
    href_rise = href_sr[1] & ~href_sr[2];
    href_fall = ~href_sr[1] & href_sr[2];
    href_on   = href_sr[1];
    vs_rise   = vsync_sr[1] & ~vsync_sr[2];
    vs_fall   = ~vsync_sr[1] & vsync_sr[2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (vs_fall) begin
          start_frame = 1'b1;
          state_nx    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          end_frame = 1'b1;
          state_nx  = enable ? WAIT_SOF : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign capturing = (state == CAPTURE);

  // Pixel index is per byte in raw mode, per byte pair otherwise.
  always_comb begin
    raw      = (mode_q == 2'd3);
    pix_idx  = raw ? byte_cntr : (byte_cntr >> 1);
    pmask    = ~({BCNT_W{1'b1}} << decim_q);
    rmask    = ~({RW{1'b1}} << decim_q);
    keep     = ((pix_idx & pmask) == '0) && ((row_cntr & rmask) == '0);
    emit     = capturing & pclk_rise & href_on & (raw | byte_cntr[0]) & keep;
    len_bad  = capturing & href_fall & len_known & (byte_cntr != line_len);
    case (mode_q)
      2'd0:    pix_word = {1'b0, even_byte[6:0], data_d2};
      2'd1:    pix_word = {even_byte, data_d2};
      2'd2:    pix_word = {8'h00, even_byte};
      default: pix_word = {8'h00, data_d2};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= '0;
      decim_q   <= '0;
      byte_cntr <= '0;
      line_len  <= '0;
      len_known <= 1'b0;
      row_cntr  <= '0;
      even_byte <= '0;
    end else begin
      if (start_frame) begin
        mode_q  <= mode;
        decim_q <= decim;
      end

      if (href_rise) begin
        byte_cntr <= '0;
      end else if (pclk_fall && href_on) begin
        byte_cntr <= byte_cntr + BCNT_W'(1);
      end

      if (pclk_rise && href_on && !byte_cntr[0]) begin
        even_byte <= data_d2;
      end

      if (start_frame) begin
        row_cntr <= '0;
      end else if (capturing && href_fall) begin
        row_cntr <= row_cntr + RW'(1);
      end

      // The first line of each frame sets the reference length.
      if (start_frame) begin
        len_known <= 1'b0;
      end else if (capturing && href_fall && !len_known) begin
        len_known <= 1'b1;
        line_len  <= byte_cntr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      sof        <= 1'b0;
      pixel      <= '0;
      row        <= '0;
      col        <= '0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= '0;
      first_pend <= 1'b0;
    end else begin
      valid      <= emit;
      sof        <= emit & first_pend;
      line_end   <= capturing & href_fall;
      frame_done <= end_frame;
      line_err   <= len_bad | (end_frame & href_on);
      if (emit) begin
        pixel <= pix_word;
        row   <= ROW_W'(row_cntr >> decim_q);
        col   <= COL_W'(pix_idx >> decim_q);
      end
      if (end_frame) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (start_frame) begin
        first_pend <= 1'b1;
      end else if (emit) begin
        first_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_multi.sv
`default_nettype none
// ============================================================================
// tb_cam_capture_multi: directed self-checking bench for cam_capture_multi
// Revision: 1.0
// ============================================================================
module tb_cam_capture_multi;

  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;
  localparam int BCNT_W = 11;
  localparam int DEC_W  = 2;

  logic              clk    = 1'b0;
  logic              rst    = 1'b0;
  logic              pclk   = 1'b0;
  logic              vsync  = 1'b0;
  logic              href   = 1'b0;
  logic [7:0]        data   = 8'h00;
  logic              enable = 1'b0;
  logic [1:0]        mode   = 2'd0;
  logic [DEC_W-1:0]  decim  = '0;
  logic [15:0]       pixel;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              valid;
  logic              sof;
  logic              line_end;
  logic              frame_done;
  logic              line_err;
  logic [7:0]        frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_pix[$];
  int          q_row[$];
  int          q_col[$];
  logic        q_sof[$];
  int n_le = 0, n_lerr = 0, n_fd = 0, err_at_le = 0, n_err_fd = 0, n_sof_stray = 0;

  logic [7:0] lb[16];
  bit         use_lb = 1'b1;

  cam_capture_multi #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BCNT_W(BCNT_W), .DEC_W(DEC_W)
  ) dut (
    .clk(clk), .rst(rst), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .enable(enable), .mode(mode), .decim(decim),
    .pixel(pixel), .row(row), .col(col), .valid(valid), .sof(sof),
    .line_end(line_end), .frame_done(frame_done), .line_err(line_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      q_pix.push_back(pixel);
      q_row.push_back(int'(row));
      q_col.push_back(int'(col));
      q_sof.push_back(sof);
    end
    if (sof && !valid) n_sof_stray++;
    if (line_end) n_le++;
    if (line_err) begin
      n_lerr++;
      if (line_end) err_at_le = n_le;
      if (frame_done) n_err_fd++;
    end
    if (frame_done) n_fd++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input int i, input logic [15:0] p,
                         input int r, input int c, input logic s);
    if (i < q_pix.size()) begin
      chk({tag, "_pix"}, q_pix[i], p);
      chk({tag, "_row"}, q_row[i], r);
      chk({tag, "_col"}, q_col[i], c);
      chk({tag, "_sof"}, q_sof[i], s);
    end else begin
      chk({tag, "_missing"}, q_pix.size(), i + 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    tick(4);
    pclk = 1'b1;
    tick(4);
    pclk = 1'b0;
  endtask

  task automatic send_line(input int n);
    href = 1'b1;
    tick(4);
    for (int i = 0; i < n; i++) send_byte(use_lb ? lb[i % 16] : 8'(i));
    tick(4);
    href = 1'b0;
    tick(6);
  endtask

  task automatic frame_start();
    vsync = 1'b0;
    tick(6);
  endtask

  task automatic frame_stop();
    vsync = 1'b1;
    tick(6);
  endtask

  task automatic clear_q();
    q_pix.delete();
    q_row.delete();
    q_col.delete();
    q_sof.delete();
  endtask

  initial begin
    int le0, lerr0, fd0;
    tick(3);
    chk("rst_outputs", {valid, sof, line_end, frame_done, line_err}, 5'b0);
    chk("rst_pixel", pixel, 16'h0000);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    rst = 1'b1;
    enable = 1'b1;
    tick(4);

    // RGB565, full resolution, four pixels.
    mode = 2'd1; decim = '0;
    vsync = 1'b1; tick(6);
    frame_start();
    lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
    lb[4] = 8'h00; lb[5] = 8'h1F; lb[6] = 8'hFF; lb[7] = 8'hFF;
    send_line(8);
    chk("rgb565_count", q_pix.size(), 4);
    chk_pix("rgb565_p0", 0, 16'hF800, 0, 0, 1'b1);
    chk_pix("rgb565_p1", 1, 16'h07E0, 0, 1, 1'b0);
    chk_pix("rgb565_p2", 2, 16'h001F, 0, 2, 1'b0);
    chk_pix("rgb565_p3", 3, 16'hFFFF, 0, 3, 1'b0);
    chk("rgb565_line_end", n_le, 1);
    frame_stop();
    chk("f1_frame_done", n_fd, 1);
    chk("f1_frame_cnt", frame_cnt, 8'd1);
    chk("f1_no_line_err", n_lerr, 0);

    // RGB555.
    clear_q();
    mode = 2'd0;
    frame_start();
    lb[0] = 8'hFC; lb[1] = 8'h1F;
    send_line(2);
    frame_stop();
    chk("rgb555_count", q_pix.size(), 1);
    chk_pix("rgb555_p0", 0, 16'h7C1F, 0, 0, 1'b1);

    // Y from YUYV.
    clear_q();
    mode = 2'd2;
    frame_start();
    lb[0] = 8'h55; lb[1] = 8'h80; lb[2] = 8'h66; lb[3] = 8'h80;
    send_line(4);
    frame_stop();
    chk("y_count", q_pix.size(), 2);
    chk_pix("y_p0", 0, 16'h0055, 0, 0, 1'b1);
    chk_pix("y_p1", 1, 16'h0066, 0, 1, 1'b0);
    chk("f3_frame_cnt", frame_cnt, 8'd3);

    // Raw bytes with decimation by 2 on both axes.
    clear_q();
    mode = 2'd3; decim = 2'd1;
    le0 = n_le;
    frame_start();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) lb[i] = 8'(16 * (l + 1) + i);
      send_line(8);
    end
    frame_stop();
    chk("raw_count", q_pix.size(), 8);
    chk_pix("raw_r0c0", 0, 16'h0010, 0, 0, 1'b1);
    chk_pix("raw_r0c3", 3, 16'h0016, 0, 3, 1'b0);
    chk_pix("raw_r1c0", 4, 16'h0030, 1, 0, 1'b0);
    chk_pix("raw_r1c2", 6, 16'h0034, 1, 2, 1'b0);
    chk("raw_line_ends", n_le - le0, 3);
    chk("raw_no_line_err", n_lerr, 0);

    // Line length mismatch on the third line only.
    clear_q();
    mode = 2'd1; decim = '0; use_lb = 1'b0;
    le0 = n_le; lerr0 = n_lerr;
    frame_start();
    send_line(640);
    send_line(640);
    send_line(638);
    frame_stop();
    use_lb = 1'b1;
    chk("len_err_count", n_lerr - lerr0, 1);
    chk("len_err_at_line3", err_at_le, le0 + 3);
    chk("len_pix_count", q_pix.size(), 959);
    chk_pix("len_first", 0, 16'h0001, 0, 0, 1'b1);
    chk_pix("len_last", 958, 16'h7C7D, 2, 318, 1'b0);
    chk("f5_frame_cnt", frame_cnt, 8'd5);

    // Enable dropped mid-frame: frame finishes, next frame ignored.
    clear_q();
    fd0 = n_fd;
    frame_start();
    lb[0] = 8'hF8; lb[1] = 8'h00;
    send_line(2);
    enable = 1'b0;
    lb[0] = 8'h07; lb[1] = 8'hE0;
    send_line(2);
    frame_stop();
    chk("dis_count", q_pix.size(), 2);
    chk_pix("dis_p1", 1, 16'h07E0, 1, 0, 1'b0);
    chk("dis_frame_done", n_fd - fd0, 1);
    chk("dis_frame_cnt", frame_cnt, 8'd6);
    clear_q();
    le0 = n_le;
    frame_start();
    send_line(2);
    frame_stop();
    chk("idle_no_valid", q_pix.size(), 0);
    chk("idle_no_line_end", n_le - le0, 0);
    chk("idle_frame_cnt", frame_cnt, 8'd6);
    enable = 1'b1;
    tick(4);
    frame_start();
    lb[0] = 8'hAB; lb[1] = 8'hCD;
    send_line(2);
    frame_stop();
    chk("reen_count", q_pix.size(), 1);
    chk_pix("reen_p0", 0, 16'hABCD, 0, 0, 1'b1);
    chk("reen_frame_cnt", frame_cnt, 8'd7);

    // Frame ends with href still high: truncated line error with frame_done.
    clear_q();
    le0 = n_le; lerr0 = n_lerr;
    frame_start();
    href = 1'b1;
    tick(4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    vsync = 1'b1;
    tick(6);
    href = 1'b0;
    tick(6);
    chk("trunc_pix", q_pix.size(), 1);
    chk("trunc_err_with_fd", n_err_fd, 1);
    chk("trunc_err_count", n_lerr - lerr0, 1);
    chk("trunc_no_line_end", n_le - le0, 0);
    chk("trunc_frame_cnt", frame_cnt, 8'd8);

    // Asynchronous reset in the middle of a line.
    frame_start();
    href = 1'b1;
    tick(4);
    send_byte(8'h12);
    send_byte(8'h34);
    tick(3);
    chk("pre_rst_pixel", pixel, 16'h1234);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_pixel", pixel, 16'h0000);
    chk("mid_rst_frame_cnt", frame_cnt, 8'd0);
    chk("mid_rst_strobes", {valid, sof, line_end, frame_done, line_err}, 5'b0);
    chk("mid_rst_rowcol", {23'd0, row, col}, 32'd0);
    tick(3);
    href = 1'b0;
    rst = 1'b1;
    tick(4);
    clear_q();
    le0 = n_le;
    send_line(4);
    chk("post_rst_no_valid", q_pix.size(), 0);
    chk("post_rst_no_line_end", n_le - le0, 0);

    // frame_cnt wrap after 256 frames.
    vsync = 1'b1;
    tick(6);
    for (int f = 0; f < 255; f++) begin
      frame_start();
      frame_stop();
    end
    chk("wrap_255", frame_cnt, 8'd255);
    frame_start();
    frame_stop();
    chk("wrap_0", frame_cnt, 8'd0);
    chk("no_stray_sof", n_sof_stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
